// File: rtl/param_clock_divider_pkg.sv
// Shared types, constants and the high-phase length helper for the
// parametrised clock divider.
package clk_div_pkg;

  // Operating mode: pass the reference clock through, or divide it.
  typedef enum logic {
    BYPASS = 1'b0,
    DIVIDE = 1'b1
  } div_state_e;

  // Smallest ratio that actually divides; 0 and 1 mean bypass.
  localparam int MIN_RATIO = 2;

  // Working width of the helper; the divider truncates the result back
  // to its own DIV_W (the result never exceeds the ratio it came from).
  localparam int FN_W = 32;

  // High-phase length: half the ratio, plus one for odd ratios when the
  // long phase is requested to be the high one.
  function automatic logic [FN_W-1:0] high_len(input logic [FN_W-1:0] ratio,
                                               input logic            duty);
    return (ratio >> 1) + {{(FN_W-1){1'b0}}, (ratio[0] & duty)};
  endfunction

endpackage

// File: rtl/param_clock_divider_if.sv
// Configuration and output bundle of the clock divider. The divider takes
// the slave view; whoever configures it and consumes its outputs takes
// the master view.
interface param_clock_divider_if #(
  parameter int DIV_W = 8
);
  logic             i_clk_en;
  logic [DIV_W-1:0] i_div_ratio;
  logic             i_odd_duty_hi;
  logic             o_div_clk;
  logic             o_rise_tick;
  logic             o_fall_tick;
  logic [DIV_W-1:0] o_active_ratio;
  logic             o_bypass;

  modport master (
    output i_clk_en, i_div_ratio, i_odd_duty_hi,
    input  o_div_clk, o_rise_tick, o_fall_tick, o_active_ratio, o_bypass
  );

  modport slave (
    input  i_clk_en, i_div_ratio, i_odd_duty_hi,
    output o_div_clk, o_rise_tick, o_fall_tick, o_active_ratio, o_bypass
  );
endinterface

// File: rtl/param_clock_divider.sv
// Runtime-ratio integer clock divider. Ratio, duty and enable are only
// sampled at divided-period boundaries, so reconfiguration never emits a
// runt pulse; leaving DIVIDE always happens in the low phase.
module param_clock_divider
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic                  i_ref_clk,
  input  logic                  i_rst_n,
  param_clock_divider_if.slave  bus
);

  div_state_e       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_ratio;
  logic             r_duty;
  logic             r_div;
  logic             r_rise;
  logic             r_fall;
  logic             r_bypass;

  div_state_e       w_state_next;
  logic [DIV_W-1:0] w_cnt_next;
  logic [DIV_W-1:0] w_ratio_next;
  logic             w_duty_next;
  logic [DIV_W-1:0] w_high_next;
  logic             w_div_next;
  logic             w_rise_next;
  logic             w_fall_next;
  logic             w_cfg_valid;

  assign w_cfg_valid = bus.i_clk_en && (bus.i_div_ratio >= DIV_W'(MIN_RATIO));

  // Next state, counter and latched config; outputs derive from next values
  // so ticks and the div flop line up with the counter they describe.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ratio_next = r_ratio;
    w_duty_next  = r_duty;

    if (r_state == BYPASS) begin
      if (w_cfg_valid) begin
        w_state_next = DIVIDE;
        w_ratio_next = bus.i_div_ratio;
        w_duty_next  = bus.i_odd_duty_hi;
        w_cnt_next   = '0;
      end
    end else begin
      if (r_cnt == r_ratio - DIV_W'(1)) begin
        // Period boundary: the only point where inputs are honoured.
        w_cnt_next = '0;
        if (w_cfg_valid) begin
          w_ratio_next = bus.i_div_ratio;
          w_duty_next  = bus.i_odd_duty_hi;
        end else begin
          w_state_next = BYPASS;
          w_ratio_next = '0;
          w_duty_next  = 1'b0;
        end
      end else begin
        w_cnt_next = r_cnt + DIV_W'(1);
      end
    end

    w_high_next = DIV_W'(high_len(FN_W'(w_ratio_next), w_duty_next));
    w_div_next  = (w_state_next == DIVIDE) && (w_cnt_next < w_high_next);
    w_rise_next = (w_state_next == DIVIDE) && (w_cnt_next == '0);
    w_fall_next = (w_state_next == DIVIDE) && (w_cnt_next == w_high_next);
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      r_state  <= BYPASS;
      r_cnt    <= '0;
      r_ratio  <= '0;
      r_duty   <= 1'b0;
      r_div    <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_bypass <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ratio  <= w_ratio_next;
      r_duty   <= w_duty_next;
      r_div    <= w_div_next;
      r_rise   <= w_rise_next;
      r_fall   <= w_fall_next;
      r_bypass <= (w_state_next == BYPASS);
    end
  end

  // Clock-path mux cell: the only logic on the clock path, kept on one line
  // so it can be replaced by a library clock mux.
  assign bus.o_div_clk = r_bypass ? i_ref_clk : r_div;

  assign bus.o_rise_tick    = r_rise;
  assign bus.o_fall_tick    = r_fall;
  assign bus.o_active_ratio = r_ratio;
  assign bus.o_bypass       = r_bypass;

endmodule
